// File: rtl/neuro_mem_pkg.sv
// Shared defaults and types for the neuromorphic memory buffer.
package neuro_mem_pkg;

    localparam int unsigned DEF_WEIGHT_W  = 80;
    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_ADC_W     = 8;
    localparam int unsigned DEF_DEPTH     = 4;
    localparam int unsigned DEF_ADC_DEPTH = 8;

    typedef struct packed {
        logic weights;
        logic data;
        logic adc;
    } req_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head word, occupancy count and full/empty status.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [WIDTH-1:0]               wdata,
    input  logic                           pop,
    output logic [WIDTH-1:0]               rdata,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    // A push into a full FIFO still lands when a pop frees the slot this cycle.
    assign do_pop  = pop & (count_q != '0);
    assign do_push = push & ((count_q != CW'(DEPTH)) | do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q] <= wdata;
    end

    assign rdata = mem[rptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/neuro_mem_buffer.sv
// Frame (weights+data) and ADC sample buffering with edge-triggered reads,
// split weights/data consumption of each frame, and sticky error flags.
module neuro_mem_buffer
    import neuro_mem_pkg::*;
#(
    parameter int unsigned WEIGHT_W  = DEF_WEIGHT_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned ADC_W     = DEF_ADC_W,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned ADC_DEPTH = DEF_ADC_DEPTH
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               en,
    input  logic [WEIGHT_W+DATA_W-1:0]         data_read,
    input  logic                               adc_valid,
    input  logic [ADC_W-1:0]                   ADC_in,
    input  logic                               load_weights,
    input  logic                               load_data,
    input  logic                               load_ADC_data,
    input  logic                               err_clr,
    output logic [WEIGHT_W-1:0]                weights_out,
    output logic [DATA_W-1:0]                  data_out,
    output logic [ADC_W-1:0]                   data_write,
    output logic                               weights_vld,
    output logic                               data_vld,
    output logic                               adc_vld,
    output logic                               frame_full,
    output logic                               frame_empty,
    output logic                               adc_full,
    output logic                               adc_empty,
    output logic [$clog2(DEPTH+1)-1:0]         frame_count,
    output logic [$clog2(ADC_DEPTH+1)-1:0]     adc_count,
    output logic                               overflow,
    output logic                               underflow
);

    localparam int unsigned FRAME_W = WEIGHT_W + DATA_W;

    req_t               req_q, ev;
    logic               armed_q;
    logic               wt_taken_q, dt_taken_q;
    logic               wt_next, dt_next;
    logic               frame_rd, frame_pop, adc_pop;
    logic               new_ovf, new_udf;
    logic [FRAME_W-1:0] frame_head;
    logic [ADC_W-1:0]   adc_head;

    sync_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (DEPTH)
    ) u_frame_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (en),
        .wdata (data_read),
        .pop   (frame_pop),
        .rdata (frame_head),
        .full  (frame_full),
        .empty (frame_empty),
        .count (frame_count)
    );

    sync_fifo #(
        .WIDTH (ADC_W),
        .DEPTH (ADC_DEPTH)
    ) u_adc_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (adc_valid),
        .wdata (ADC_in),
        .pop   (adc_pop),
        .rdata (adc_head),
        .full  (adc_full),
        .empty (adc_empty),
        .count (adc_count)
    );

    // armed_q masks the first cycle after reset so a request held high
    // across reset release is not mistaken for a rising edge.
    always_comb begin
        ev         = '0;
        ev.weights = armed_q & load_weights  & ~req_q.weights;
        ev.data    = armed_q & load_data     & ~req_q.data;
        ev.adc     = armed_q & load_ADC_data & ~req_q.adc;

        frame_rd  = (ev.weights | ev.data) & ~frame_empty;
        wt_next   = wt_taken_q | (ev.weights & ~frame_empty);
        dt_next   = dt_taken_q | (ev.data & ~frame_empty);
        frame_pop = frame_rd & wt_next & dt_next;
        adc_pop   = ev.adc & ~adc_empty;

        new_ovf = (en & frame_full & ~frame_pop) | (adc_valid & adc_full & ~adc_pop);
        new_udf = ((ev.weights | ev.data) & frame_empty) | (ev.adc & adc_empty);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q       <= '0;
            armed_q     <= 1'b0;
            wt_taken_q  <= 1'b0;
            dt_taken_q  <= 1'b0;
            weights_out <= '0;
            data_out    <= '0;
            data_write  <= '0;
            weights_vld <= 1'b0;
            data_vld    <= 1'b0;
            adc_vld     <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            req_q       <= {load_weights, load_data, load_ADC_data};
            armed_q     <= 1'b1;
            weights_vld <= ev.weights & ~frame_empty;
            data_vld    <= ev.data & ~frame_empty;
            adc_vld     <= adc_pop;
            if (ev.weights & ~frame_empty) weights_out <= frame_head[FRAME_W-1:DATA_W];
            if (ev.data & ~frame_empty)    data_out    <= frame_head[DATA_W-1:0];
            if (adc_pop)                   data_write  <= adc_head;
            if (frame_pop) begin
                wt_taken_q <= 1'b0;
                dt_taken_q <= 1'b0;
            end else begin
                wt_taken_q <= wt_next;
                dt_taken_q <= dt_next;
            end
            overflow  <= (overflow & ~err_clr) | new_ovf;
            underflow <= (underflow & ~err_clr) | new_udf;
        end
    end

endmodule

// File: tb/tb_neuro_mem_buffer.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed literal checks.
module tb_neuro_mem_buffer;

    localparam int WW = 80;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int DEP = 4;
    localparam int ADEP = 8;
    localparam int FW = WW + DW;

    logic          clk = 1'b0;
    logic          rst_n, en, adc_valid, load_weights, load_data, load_ADC_data, err_clr;
    logic [FW-1:0] data_read;
    logic [AW-1:0] ADC_in;
    logic [WW-1:0] weights_out;
    logic [DW-1:0] data_out;
    logic [AW-1:0] data_write;
    logic          weights_vld, data_vld, adc_vld;
    logic          frame_full, frame_empty, adc_full, adc_empty;
    logic [2:0]    frame_count;
    logic [3:0]    adc_count;
    logic          overflow, underflow;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    neuro_mem_buffer #(
        .WEIGHT_W  (WW),
        .DATA_W    (DW),
        .ADC_W     (AW),
        .DEPTH     (DEP),
        .ADC_DEPTH (ADEP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .data_read     (data_read),
        .adc_valid     (adc_valid),
        .ADC_in        (ADC_in),
        .load_weights  (load_weights),
        .load_data     (load_data),
        .load_ADC_data (load_ADC_data),
        .err_clr       (err_clr),
        .weights_out   (weights_out),
        .data_out      (data_out),
        .data_write    (data_write),
        .weights_vld   (weights_vld),
        .data_vld      (data_vld),
        .adc_vld       (adc_vld),
        .frame_full    (frame_full),
        .frame_empty   (frame_empty),
        .adc_full      (adc_full),
        .adc_empty     (adc_empty),
        .frame_count   (frame_count),
        .adc_count     (adc_count),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [FW-1:0] frame(input logic [WW-1:0] w, input logic [DW-1:0] d);
        return {w, d};
    endfunction

    // Reference model: plain queues, taken flags, previous request levels.
    logic [FW-1:0] fq[$];
    logic [AW-1:0] aq[$];
    bit            m_wt, m_dt, m_pw, m_pd, m_pa, m_armed, started;
    logic [WW-1:0] m_w;
    logic [DW-1:0] m_d;
    logic [AW-1:0] m_a;
    bit            m_wv, m_dv, m_av, m_ov, m_ud;
    bit            ew, ed, ea, nov, nud;

    always @(posedge clk) begin
        started = 1'b1;
        if (!rst_n) begin
            fq.delete();
            aq.delete();
            m_wt = 0; m_dt = 0; m_pw = 0; m_pd = 0; m_pa = 0; m_armed = 0;
            m_w = '0; m_d = '0; m_a = '0;
            m_wv = 0; m_dv = 0; m_av = 0; m_ov = 0; m_ud = 0;
        end else begin
            ew = m_armed && load_weights && !m_pw;
            ed = m_armed && load_data && !m_pd;
            ea = m_armed && load_ADC_data && !m_pa;
            nov = 0; nud = 0;
            m_wv = 0; m_dv = 0; m_av = 0;
            if (ew || ed) begin
                if (fq.size() == 0) nud = 1;
                else begin
                    if (ew) begin m_w = fq[0][FW-1:DW]; m_wv = 1; m_wt = 1; end
                    if (ed) begin m_d = fq[0][DW-1:0]; m_dv = 1; m_dt = 1; end
                    if (m_wt && m_dt) begin void'(fq.pop_front()); m_wt = 0; m_dt = 0; end
                end
            end
            if (ea) begin
                if (aq.size() == 0) nud = 1;
                else begin m_a = aq.pop_front(); m_av = 1; end
            end
            if (en) begin
                if (fq.size() < DEP) fq.push_back(data_read); else nov = 1;
            end
            if (adc_valid) begin
                if (aq.size() < ADEP) aq.push_back(ADC_in); else nov = 1;
            end
            m_ov = (m_ov && !err_clr) || nov;
            m_ud = (m_ud && !err_clr) || nud;
            m_pw = load_weights; m_pd = load_data; m_pa = load_ADC_data;
            m_armed = 1;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("weights_out", weights_out, m_w);
            check("data_out", data_out, m_d);
            check("data_write", data_write, m_a);
            check("weights_vld", weights_vld, m_wv);
            check("data_vld", data_vld, m_dv);
            check("adc_vld", adc_vld, m_av);
            check("frame_count", frame_count, fq.size());
            check("adc_count", adc_count, aq.size());
            check("frame_full", frame_full, fq.size() == DEP);
            check("frame_empty", frame_empty, fq.size() == 0);
            check("adc_full", adc_full, aq.size() == ADEP);
            check("adc_empty", adc_empty, aq.size() == 0);
            check("overflow", overflow, m_ov);
            check("underflow", underflow, m_ud);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [WW-1:0] w, input logic [DW-1:0] d);
        en = 1'b1;
        data_read = frame(w, d);
        tick();
        en = 1'b0;
    endtask

    // One low cycle, then one high cycle; caller checks right after.
    task automatic pulse(input bit w, input bit d, input bit a);
        tick();
        load_weights = w;
        load_data = d;
        load_ADC_data = a;
        tick();
        load_weights = 1'b0;
        load_data = 1'b0;
        load_ADC_data = 1'b0;
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    int n;

    initial begin
        rst_n = 0; en = 0; data_read = '0; adc_valid = 0; ADC_in = '0;
        load_weights = 0; load_data = 0; load_ADC_data = 0; err_clr = 0;
        tick(); tick();
        rst_n = 1;
        tick(); tick();
        check("rst frame_empty", frame_empty, 1);
        check("rst adc_empty", adc_empty, 1);
        check("rst frame_count", frame_count, 0);
        check("rst weights_out", weights_out, 0);

        // Basic split consumption
        push_frame(80'd1, 32'hA);
        push_frame(80'd2, 32'hB);
        check("t1 count2", frame_count, 2);
        pulse(1, 0, 0);
        check("t1 weights", weights_out, 1);
        check("t1 wvld", weights_vld, 1);
        check("t1 no pop", frame_count, 2);
        pulse(0, 1, 0);
        check("t1 data", data_out, 32'hA);
        check("t1 dvld", data_vld, 1);
        check("t1 count1", frame_count, 1);
        pulse(1, 1, 0);
        check("t1 both w", weights_out, 2);
        check("t1 both d", data_out, 32'hB);
        check("t1 empty", frame_empty, 1);

        // Underflow and clear
        pulse(0, 1, 0);
        check("t2 data held", data_out, 32'hB);
        check("t2 no dvld", data_vld, 0);
        check("t2 underflow", underflow, 1);
        clear_err();
        check("t2 cleared", underflow, 0);

        // Overflow on fifth write
        for (int i = 0; i < 5; i++) push_frame(80'(16 + i), 32'(32 + i));
        check("t3 full", frame_full, 1);
        check("t3 overflow", overflow, 1);
        check("t3 count4", frame_count, 4);
        clear_err();
        for (int i = 0; i < 4; i++) begin
            pulse(1, 1, 0);
            check("t3 drain w", weights_out, 16 + i);
            check("t3 drain d", data_out, 32 + i);
        end
        pulse(1, 0, 0);
        check("t3 fifth absent", weights_out, 19);
        check("t3 underflow", underflow, 1);
        clear_err();

        // Held request yields one pulse
        push_frame(80'h55, 32'h66);
        tick();
        load_weights = 1;
        n = 0;
        repeat (10) begin
            tick();
            if (weights_vld) n++;
        end
        load_weights = 0;
        check("t4 one pulse", n, 1);
        check("t4 no pop", frame_count, 1);
        pulse(0, 1, 0);
        check("t4 data", data_out, 32'h66);
        check("t4 popped", frame_count, 0);

        // ADC FIFO fill, drain, wrap
        adc_valid = 1;
        for (int i = 0; i < 8; i++) begin
            ADC_in = 8'(16 + i);
            tick();
        end
        adc_valid = 0;
        check("t5 adc_full", adc_full, 1);
        check("t5 adc_count", adc_count, 8);
        for (int i = 0; i < 9; i++) begin
            pulse(0, 0, 1);
            if (i < 8) begin
                check("t5 sample", data_write, 16 + i);
                check("t5 avld", adc_vld, 1);
            end else begin
                check("t5 held", data_write, 8'h17);
                check("t5 no avld", adc_vld, 0);
                check("t5 underflow", underflow, 1);
            end
        end
        clear_err();
        adc_valid = 1;
        for (int i = 0; i < 3; i++) begin
            ADC_in = 8'(48 + i);
            tick();
        end
        adc_valid = 0;
        for (int i = 0; i < 3; i++) begin
            pulse(0, 0, 1);
            check("t5 refill", data_write, 48 + i);
        end
        tick();
        adc_valid = 1; ADC_in = 8'h77; load_ADC_data = 1;
        tick();
        adc_valid = 0; load_ADC_data = 0;
        check("t5 no bypass", data_write, 8'h32);
        check("t5 empty read udf", underflow, 1);
        check("t5 write kept", adc_count, 1);
        pulse(0, 0, 1);
        check("t5 late read", data_write, 8'h77);
        clear_err();

        // Write and pop on full frame FIFO
        for (int i = 0; i < 4; i++) push_frame(80'(64 + i), 32'(80 + i));
        tick();
        en = 1; data_read = frame(80'h44, 32'h54); load_weights = 1; load_data = 1;
        tick();
        en = 0; load_weights = 0; load_data = 0;
        check("t6 count4", frame_count, 4);
        check("t6 no ovf", overflow, 0);
        check("t6 w", weights_out, 80'h40);
        check("t6 d", data_out, 32'h50);
        for (int i = 0; i < 4; i++) begin
            pulse(1, 1, 0);
            check("t6 drain", weights_out, 65 + i);
        end

        // Reset mid-operation with a held request
        push_frame(80'h9, 32'h9);
        push_frame(80'hA, 32'hA);
        adc_valid = 1; ADC_in = 8'h5; tick(); adc_valid = 0;
        rst_n = 0; load_weights = 1;
        tick();
        rst_n = 1;
        repeat (3) begin
            tick();
            check("t7 no event", weights_vld, 0);
        end
        load_weights = 0;
        check("t7 frame_empty", frame_empty, 1);
        check("t7 adc_empty", adc_empty, 1);
        check("t7 weights zero", weights_out, 0);
        pulse(1, 0, 0);
        check("t7 udf", underflow, 1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/neuro_mem_buffer.md
NEURO_MEM_BUFFER -- requirements
Module: neuro_mem_buffer

Interface
REQ-001 Parameter WEIGHT_W, default 80, width of one weight word.
REQ-002 Parameter DATA_W, default 32, width of one data word.
REQ-003 Parameter ADC_W, default 8, width of one ADC sample.
REQ-004 Parameter DEPTH, default 4, frame FIFO entries; power of 2, >= 2.
REQ-005 Parameter ADC_DEPTH, default 8, ADC FIFO entries; power of 2, >= 2.
REQ-006 Port clk, input, 1, sole clock; all logic on its rising edge.
REQ-007 Port rst_n, input, 1, synchronous active-low reset.
REQ-008 Port en, input, 1, write strobe; captures one frame from data_read per cycle high.
REQ-009 Port data_read, input, WEIGHT_W+DATA_W, frame: weights in upper WEIGHT_W bits, data in lower DATA_W bits.
REQ-010 Port adc_valid, input, 1, writes ADC_in into the ADC FIFO per cycle high.
REQ-011 Port ADC_in, input, ADC_W, ADC sample.
REQ-012 Ports load_weights, load_data, load_ADC_data, input, 1 each, read requests; level signals, acted on at rising edge only.
REQ-013 Port err_clr, input, 1, clears sticky error flags.
REQ-014 Ports weights_out (WEIGHT_W), data_out (DATA_W), data_write (ADC_W), output, registered read data.
REQ-015 Ports weights_vld, data_vld, adc_vld, output, 1 each, one-cycle pulse when matching output updates.
REQ-016 Ports frame_full, frame_empty, adc_full, adc_empty, output, 1 each, FIFO status.
REQ-017 Ports frame_count ($clog2(DEPTH+1)), adc_count ($clog2(ADC_DEPTH+1)), output, occupancy.
REQ-018 Ports overflow, underflow, output, 1 each, sticky error flags.

Function
REQ-019 Read requests SHALL be edge-detected in clk domain: event = level & ~previous-cycle level; no logic clocked by request signals.
REQ-020 Event sampled at edge N SHALL update output register and assert its vld pulse after edge N; vld deasserts after edge N+1 unless a new event occurs.
REQ-021 Frame FIFO head SHALL be read non-destructively; weights event copies head weights to weights_out and sets weights_taken; data event copies head data to data_out and sets data_taken.
REQ-022 Head frame SHALL pop when weights_taken and data_taken are both set; both flags clear on pop.
REQ-023 Repeated weights (or data) event on a head already so taken SHALL re-output same value without popping.
REQ-024 Simultaneous weights and data events on fresh head SHALL output both and pop in that cycle.
REQ-025 ADC event SHALL pop ADC FIFO head into data_write.
REQ-026 Write when FIFO full and no pop same cycle SHALL be dropped, set overflow; contents unchanged.
REQ-027 Write and pop same cycle when full SHALL both succeed; count unchanged.
REQ-028 Read event when FIFO empty SHALL leave output unchanged, no vld pulse, set underflow; simultaneous write into empty FIFO accepted, no bypass.
REQ-029 Pointers SHALL wrap modulo depth; count SHALL range 0..depth exactly.
REQ-030 err_clr SHALL clear overflow/underflow; same-cycle new error SHALL win (flag stays set).

Reset
REQ-031 rst_n low at clk edge SHALL zero all outputs, pointers, counts, taken flags, edge-detect history, errors; frame_empty=adc_empty=1.
REQ-032 Reset mid-operation SHALL discard all stored entries; request held high through reset release SHALL NOT produce an event.

Structure
REQ-033 Package neuro_mem_pkg SHALL hold default width/depth constants.
REQ-034 Sub-module sync_fifo (show-ahead head, push/pop, count, full/empty) SHALL be instantiated twice: frame and ADC.

Verification
REQ-035 Reset, write frames {W=1,D=0xA},{W=2,D=0xB}; pulse load_weights then load_data -> weights_out=1, data_out=0xA, frame_count 2->1.
REQ-036 Five en writes, DEPTH=4 -> frame_full=1, overflow=1, 5th frame absent from later reads.
REQ-037 load_data on empty FIFO -> data_out unchanged, no data_vld, underflow=1; err_clr -> underflow=0.
REQ-038 load_weights held high 10 cycles -> exactly one weights_vld pulse, no pop.
REQ-039 ADC samples 0x10..0x17 written, 9 load_ADC_data pulses -> data_write 0x10..0x17 in order, 9th sets underflow, pointers wrapped correctly on refill.
REQ-040 Full frame FIFO, en with both load events same cycle -> write accepted, frame_count stays 4, no overflow.
